// File: rtl/mips_core_pkg.sv
// Shared types for the two-thread MIPS core front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_core_pkg;

  localparam int NUM_THREADS = 2;

  typedef logic ThreadId;

  // Per-thread fetch state; HALTED is terminal until reset.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BLOCKED = 2'd1,
    HALTED  = 2'd2
  } ThreadState;

endpackage

// File: rtl/thread_fetch_unit_if.sv
// Bundle between the fetch unit and its neighbours (decoder, EX, CP0, I-cache).
// Latency: n/a (wires only). Perf-counter outputs exist only with FETCH_PERF_COUNTERS_EN.
// Backpressure: i_stall freezes fetch; there is no per-signal handshake.
// Modports: master = core side driving i_*, slave = fetch unit driving o_*.
interface thread_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  i_stall;
  logic                  i_block_valid;
  logic                  i_block_thread;
  logic                  i_resolve_valid;
  logic                  i_resolve_thread;
  logic                  i_resolve_taken;
  logic [ADDR_WIDTH-1:0] i_resolve_target;
  logic                  i_halt_valid;
  logic                  i_halt_thread;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_thread_id;
  logic                  o_valid;
  logic                  o_all_halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]           o_fetch_cnt_t0;
  logic [31:0]           o_fetch_cnt_t1;
  logic [31:0]           o_bubble_cnt;

  modport master (
    output i_stall, i_block_valid, i_block_thread, i_resolve_valid, i_resolve_thread,
           i_resolve_taken, i_resolve_target, i_halt_valid, i_halt_thread,
    input  o_pc, o_thread_id, o_valid, o_all_halted,
           o_fetch_cnt_t0, o_fetch_cnt_t1, o_bubble_cnt
  );
  modport slave (
    input  i_stall, i_block_valid, i_block_thread, i_resolve_valid, i_resolve_thread,
           i_resolve_taken, i_resolve_target, i_halt_valid, i_halt_thread,
    output o_pc, o_thread_id, o_valid, o_all_halted,
           o_fetch_cnt_t0, o_fetch_cnt_t1, o_bubble_cnt
  );
`else
  modport master (
    output i_stall, i_block_valid, i_block_thread, i_resolve_valid, i_resolve_thread,
           i_resolve_taken, i_resolve_target, i_halt_valid, i_halt_thread,
    input  o_pc, o_thread_id, o_valid, o_all_halted
  );
  modport slave (
    input  i_stall, i_block_valid, i_block_thread, i_resolve_valid, i_resolve_thread,
           i_resolve_taken, i_resolve_target, i_halt_valid, i_halt_thread,
    output o_pc, o_thread_id, o_valid, o_all_halted
  );
`endif
endinterface

// File: rtl/thread_pc_slot.sv
// One hardware thread's PC and ThreadState with advance/redirect/block/halt priority.
// Latency: all updates land on the next clock edge.
// Backpressure: advance_i is already qualified by the caller with the global stall.
// Ports: clk/rst, advance_i, block_i, resolve_i/taken_i/target_i, halt_i -> pc_o, state_o.
module thread_pc_slot
  import mips_core_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance_i,
  input  logic                  block_i,
  input  logic                  resolve_i,
  input  logic                  taken_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output ThreadState            state_o
);

  ThreadState            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Later assignments win: redirect beats pc+4, block beats resolve, halt beats all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (advance_i) pc_d = pc_q + ADDR_WIDTH'(4);
    if (state_q != HALTED) begin
      if (resolve_i) begin
        if (taken_i) pc_d = target_i & ~ADDR_WIDTH'(3);
        if (state_q == BLOCKED) state_d = RUN;
      end
      if (block_i) state_d = BLOCKED;
      if (halt_i)  state_d = HALTED;
    end
  end

  assign pc_o    = pc_q;
  assign state_o = state_q;

endmodule

// File: rtl/thread_fetch_unit.sv
// Two-thread PC generation and round-robin fetch arbitration feeding I-cache and decoder.
// Latency: one cycle from selection to o_pc/o_thread_id/o_valid (registered outputs).
// Backpressure: i_stall holds o_* and freezes PC advance; block/resolve/halt still apply.
// Ports: clk, rst (sync, active high), bus (thread_fetch_unit_if.slave).
// Optional: FETCH_PERF_COUNTERS_EN adds saturating fetch/bubble counters on the bus.
module thread_fetch_unit
  import mips_core_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC_T0 = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC_T1 = 16'h0400
) (
  input  logic               clk,
  input  logic               rst,
  thread_fetch_unit_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pc_w [NUM_THREADS];
  ThreadState            st_w [NUM_THREADS];
  logic [NUM_THREADS-1:0] runnable;
  logic                  any_run;
  logic                  fetch;
  ThreadId               sel;

  ThreadId               last_q, last_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  ThreadId               tid_q, tid_d;
  logic                  all_halted_q, all_halted_d;

  // Arbiter: alternate when both are runnable, otherwise take whichever one is.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) runnable[t] = (st_w[t] == RUN);
    any_run = |runnable;
    sel     = (&runnable) ? ~last_q : ThreadId'(runnable[1]);
    fetch   = any_run && !bus.i_stall;
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
    thread_pc_slot #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   ((t == 0) ? RESET_PC_T0 : RESET_PC_T1)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .advance_i (fetch && (sel == ThreadId'(t))),
      .block_i   (bus.i_block_valid && (bus.i_block_thread == ThreadId'(t))),
      .resolve_i (bus.i_resolve_valid && (bus.i_resolve_thread == ThreadId'(t))),
      .taken_i   (bus.i_resolve_taken),
      .target_i  (bus.i_resolve_target),
      .halt_i    (bus.i_halt_valid && (bus.i_halt_thread == ThreadId'(t))),
      .pc_o      (pc_w[t]),
      .state_o   (st_w[t])
    );
  end

  always_comb begin
    last_d       = last_q;
    valid_d      = valid_q;
    pc_out_d     = pc_out_q;
    tid_d        = tid_q;
    // Halt status tracks thread state even while fetch is stalled.
    all_halted_d = (st_w[0] == HALTED) && (st_w[1] == HALTED);
    if (!bus.i_stall) begin
      valid_d  = any_run;
      pc_out_d = pc_w[sel];
      tid_d    = sel;
      if (any_run) last_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      valid_q      <= 1'b0;
      pc_out_q     <= '0;
      tid_q        <= 1'b0;
      all_halted_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      valid_q      <= valid_d;
      pc_out_q     <= pc_out_d;
      tid_q        <= tid_d;
      all_halted_q <= all_halted_d;
    end
  end

  assign bus.o_pc         = pc_out_q;
  assign bus.o_thread_id  = tid_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_all_halted = all_halted_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_t0_q, fetch_cnt_t1_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_t0_q <= '0;
      fetch_cnt_t1_q <= '0;
      bubble_cnt_q   <= '0;
    end else if (!bus.i_stall) begin
      if (!any_run) begin
        if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else if (sel == 1'b0) begin
        if (fetch_cnt_t0_q != '1) fetch_cnt_t0_q <= fetch_cnt_t0_q + 32'd1;
      end else begin
        if (fetch_cnt_t1_q != '1) fetch_cnt_t1_q <= fetch_cnt_t1_q + 32'd1;
      end
    end
  end

  assign bus.o_fetch_cnt_t0 = fetch_cnt_t0_q;
  assign bus.o_fetch_cnt_t1 = fetch_cnt_t1_q;
  assign bus.o_bubble_cnt   = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Self-checking bench for thread_fetch_unit: directed scenarios plus randomized traffic
// compared against a per-thread behavioural model.
module tb_thread_fetch_unit;

  localparam int S_RUN = 0, S_BLK = 1, S_HALT = 2;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  logic w_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  thread_fetch_unit_if #(.ADDR_WIDTH(16)) tfu ();
  thread_fetch_unit_if #(.ADDR_WIDTH(16)) twu ();

  thread_fetch_unit #(.ADDR_WIDTH(16)) u_dut (.clk(clk), .rst(tb_rst), .bus(tfu));
  thread_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC_T0(16'hFFFC)) u_wrap (.clk(clk), .rst(w_rst), .bus(twu));

  // Behavioural model state
  int          m_pc [2];
  int          m_st [2];
  int          m_last;
  bit          e_valid, e_allh;
  int          e_pc, e_tid;
  int unsigned e_fc [2];
  int unsigned e_bub;

  function automatic string got_s();
    return $sformatf("got v=%0b t=%0b pc=%h ah=%0b", tfu.o_valid, tfu.o_thread_id, tfu.o_pc, tfu.o_all_halted);
  endfunction
  function automatic string exp_s();
    return $sformatf("exp v=%0b t=%0d pc=%h ah=%0b", e_valid, e_tid, e_pc[15:0], e_allh);
  endfunction

  task automatic idle();
    tfu.i_stall = 0; tfu.i_block_valid = 0; tfu.i_block_thread = 0;
    tfu.i_resolve_valid = 0; tfu.i_resolve_thread = 0; tfu.i_resolve_taken = 0;
    tfu.i_resolve_target = '0; tfu.i_halt_valid = 0; tfu.i_halt_thread = 0;
  endtask

  // One cycle of the spec's rules, applied to the inputs currently driven.
  task automatic model_step(input bit r);
    int npc [2];
    int nst [2];
    bit r0, r1, allh_now;
    int sel;
    if (r) begin
      m_pc[0] = 0; m_pc[1] = 'h400; m_st[0] = S_RUN; m_st[1] = S_RUN; m_last = 1;
      e_valid = 0; e_pc = 0; e_tid = 0; e_allh = 0;
      e_fc[0] = 0; e_fc[1] = 0; e_bub = 0;
      return;
    end
    r0 = (m_st[0] == S_RUN);
    r1 = (m_st[1] == S_RUN);
    allh_now = (m_st[0] == S_HALT) && (m_st[1] == S_HALT);
    if (r0 && r1) sel = 1 - m_last; else sel = r1 ? 1 : 0;
    npc = m_pc;
    nst = m_st;
    if (!tfu.i_stall) begin
      e_valid = r0 || r1;
      e_pc = m_pc[sel];
      e_tid = sel;
      if (r0 || r1) begin
        npc[sel] = (m_pc[sel] + 4) % 65536;
        m_last = sel;
        if (e_fc[sel] != 32'hFFFF_FFFF) e_fc[sel]++;
      end else if (e_bub != 32'hFFFF_FFFF) e_bub++;
    end
    for (int t = 0; t < 2; t++) begin
      if (m_st[t] != S_HALT) begin
        if (tfu.i_resolve_valid && int'(tfu.i_resolve_thread) == t) begin
          if (tfu.i_resolve_taken) npc[t] = int'(tfu.i_resolve_target) & 'hFFFC;
          if (m_st[t] == S_BLK) nst[t] = S_RUN;
        end
        if (tfu.i_block_valid && int'(tfu.i_block_thread) == t) nst[t] = S_BLK;
        if (tfu.i_halt_valid && int'(tfu.i_halt_thread) == t) nst[t] = S_HALT;
      end
    end
    e_allh = allh_now;
    m_pc = npc;
    m_st = nst;
  endtask

  task automatic tick(input bit r);
    tb_rst = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    tick(1);
    tick(1);
    checks++; if (tfu.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", tfu.o_valid); end
    checks++; if (tfu.o_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", tfu.o_pc); end
    checks++; if (tfu.o_thread_id !== 1'b0) begin failures++; $display("FAIL reset_tid got=%0b exp=0", tfu.o_thread_id); end
    checks++; if (tfu.o_all_halted !== 1'b0) begin failures++; $display("FAIL reset_allh got=%0b exp=0", tfu.o_all_halted); end
  endtask

  task automatic test_round_robin();
    int et [4] = '{0, 1, 0, 1};
    int ep [4] = '{'h0, 'h400, 'h4, 'h404};
    idle();
    tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(0);
      checks++;
      if (tfu.o_valid !== 1'b1 || tfu.o_thread_id !== 1'(et[i]) || tfu.o_pc !== 16'(ep[i])) begin
        failures++; $display("FAIL rr_seq i=%0d %s need t=%0d pc=%h", i, got_s(), et[i], ep[i][15:0]);
      end
    end
  endtask

  task automatic test_block_resolve();
    int et [10] = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 1};
    int ep [10] = '{'h0, 'h400, 'h4, 'h404, 'h408, 'h40C, 'h410, 'h414, 'h200, 'h418};
    idle();
    tick(1);
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 3) begin tfu.i_block_valid = 1; tfu.i_block_thread = 0; end
      if (i == 7) begin
        tfu.i_resolve_valid = 1; tfu.i_resolve_thread = 0;
        tfu.i_resolve_taken = 1; tfu.i_resolve_target = 16'h0203;
      end
      tick(0);
      checks++;
      if (tfu.o_valid !== 1'b1 || tfu.o_thread_id !== 1'(et[i]) || tfu.o_pc !== 16'(ep[i])) begin
        failures++; $display("FAIL block_seq i=%0d %s need t=%0d pc=%h", i, got_s(), et[i], ep[i][15:0]);
      end
      checks++;
      if (tfu.o_valid !== e_valid || (e_valid && (tfu.o_pc !== 16'(e_pc) || tfu.o_thread_id !== 1'(e_tid)))) begin
        failures++; $display("FAIL block_model i=%0d %s %s", i, got_s(), exp_s());
      end
    end
  endtask

  // Continues from the state left by test_block_resolve: o shows (1,0x418).
  task automatic test_stall();
    int et [7] = '{0, 1, 1, 1, 1, 0, 1};
    int ep [7] = '{'h204, 'h41C, 'h41C, 'h41C, 'h41C, 'h208, 'h420};
    for (int i = 0; i < 7; i++) begin
      idle();
      tfu.i_stall = (i >= 2 && i <= 4);
      tick(0);
      checks++;
      if (tfu.o_valid !== 1'b1 || tfu.o_thread_id !== 1'(et[i]) || tfu.o_pc !== 16'(ep[i])) begin
        failures++; $display("FAIL stall_seq i=%0d %s need t=%0d pc=%h", i, got_s(), et[i], ep[i][15:0]);
      end
      checks++;
      if (tfu.o_valid !== e_valid || (e_valid && (tfu.o_pc !== 16'(e_pc) || tfu.o_thread_id !== 1'(e_tid)))) begin
        failures++; $display("FAIL stall_model i=%0d %s %s", i, got_s(), exp_s());
      end
    end
    idle();
  endtask

  task automatic test_halt_bubble();
    bit ev [7] = '{1, 1, 0, 0, 1, 1, 0};
    int ep [7] = '{'h0, 'h4, 0, 0, 'h8, 'hC, 0};
    bit ea [7] = '{0, 0, 0, 0, 0, 0, 1};
    idle();
    tick(1);
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin tfu.i_halt_valid = 1; tfu.i_halt_thread = 1; end
        1: begin tfu.i_block_valid = 1; tfu.i_block_thread = 0; end
        3: begin tfu.i_resolve_valid = 1; tfu.i_resolve_thread = 0; tfu.i_resolve_taken = 0; tfu.i_resolve_target = 16'h1234; end
        5: begin tfu.i_halt_valid = 1; tfu.i_halt_thread = 0; end
        default: ;
      endcase
      tick(0);
      checks++;
      if (tfu.o_valid !== ev[i] || tfu.o_all_halted !== ea[i] || (ev[i] && (tfu.o_thread_id !== 1'b0 || tfu.o_pc !== 16'(ep[i])))) begin
        failures++; $display("FAIL halt_seq i=%0d %s need v=%0b t=0 pc=%h ah=%0b", i, got_s(), ev[i], ep[i][15:0], ea[i]);
      end
      checks++;
      if (tfu.o_valid !== e_valid || tfu.o_all_halted !== e_allh ||
          (e_valid && (tfu.o_pc !== 16'(e_pc) || tfu.o_thread_id !== 1'(e_tid)))) begin
        failures++; $display("FAIL halt_model i=%0d %s %s", i, got_s(), exp_s());
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    tick(1);
    tfu.i_halt_valid = 1; tfu.i_halt_thread = 1;
    tick(0);
    idle();
    tfu.i_block_valid = 1; tfu.i_block_thread = 0;
    tick(0);
    idle();
    tick(0);
    checks++; if (tfu.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_pre_bubble got v=%0b exp 0", tfu.o_valid); end
    // Reset overrides a concurrent resolve/block.
    tfu.i_resolve_valid = 1; tfu.i_resolve_thread = 0; tfu.i_resolve_taken = 1; tfu.i_resolve_target = 16'h5550;
    tick(1);
    idle();
    checks++;
    if (tfu.o_valid !== 1'b0 || tfu.o_pc !== 16'h0 || tfu.o_thread_id !== 1'b0 || tfu.o_all_halted !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs %s need v=0 t=0 pc=0000 ah=0", got_s());
    end
`ifdef FETCH_PERF_COUNTERS_EN
    checks++;
    if (tfu.o_fetch_cnt_t0 !== 32'd0 || tfu.o_fetch_cnt_t1 !== 32'd0 || tfu.o_bubble_cnt !== 32'd0) begin
      failures++; $display("FAIL rstmid_counters got %0d %0d %0d need 0 0 0", tfu.o_fetch_cnt_t0, tfu.o_fetch_cnt_t1, tfu.o_bubble_cnt);
    end
`endif
    tick(0);
    checks++;
    if (tfu.o_valid !== 1'b1 || tfu.o_thread_id !== 1'b0 || tfu.o_pc !== 16'h0000) begin
      failures++; $display("FAIL rstmid_t0 %s need v=1 t=0 pc=0000", got_s());
    end
    tick(0);
    checks++;
    if (tfu.o_valid !== 1'b1 || tfu.o_thread_id !== 1'b1 || tfu.o_pc !== 16'h0400) begin
      failures++; $display("FAIL rstmid_t1 %s need v=1 t=1 pc=0400", got_s());
    end
  endtask

  task automatic test_random();
    idle();
    tick(1);
    for (int i = 0; i < 600; i++) begin
      idle();
      tfu.i_stall = ($urandom_range(0, 3) == 0);
      tfu.i_block_valid = ($urandom_range(0, 6) == 0);
      tfu.i_block_thread = 1'($urandom_range(0, 1));
      tfu.i_resolve_valid = ($urandom_range(0, 4) == 0);
      tfu.i_resolve_thread = 1'($urandom_range(0, 1));
      tfu.i_resolve_taken = 1'($urandom_range(0, 1));
      tfu.i_resolve_target = 16'($urandom_range(0, 65535));
      tfu.i_halt_valid = ($urandom_range(0, 40) == 0);
      tfu.i_halt_thread = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 60) == 0);
      checks++;
      if (tfu.o_valid !== e_valid || tfu.o_all_halted !== e_allh ||
          (e_valid && (tfu.o_pc !== 16'(e_pc) || tfu.o_thread_id !== 1'(e_tid)))) begin
        failures++; $display("FAIL rand_model i=%0d %s %s", i, got_s(), exp_s());
      end
`ifdef FETCH_PERF_COUNTERS_EN
      checks++;
      if (tfu.o_fetch_cnt_t0 !== e_fc[0] || tfu.o_fetch_cnt_t1 !== e_fc[1] || tfu.o_bubble_cnt !== e_bub) begin
        failures++; $display("FAIL rand_counters i=%0d got %0d %0d %0d need %0d %0d %0d", i,
                             tfu.o_fetch_cnt_t0, tfu.o_fetch_cnt_t1, tfu.o_bubble_cnt, e_fc[0], e_fc[1], e_bub);
      end
`endif
    end
    idle();
  endtask

  task automatic test_wrap();
    int ep [3] = '{'hFFFC, 'h0000, 'h0004};
    w_rst = 1;
    @(posedge clk); #1;
    w_rst = 0;
    twu.i_halt_valid = 1; twu.i_halt_thread = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      twu.i_halt_valid = 0;
      checks++;
      if (twu.o_valid !== 1'b1 || twu.o_thread_id !== 1'b0 || twu.o_pc !== 16'(ep[i])) begin
        failures++; $display("FAIL wrap_seq i=%0d got v=%0b t=%0b pc=%h need v=1 t=0 pc=%h",
                             i, twu.o_valid, twu.o_thread_id, twu.o_pc, ep[i][15:0]);
      end
    end
  endtask

  initial begin
    idle();
    twu.i_stall = 0; twu.i_block_valid = 0; twu.i_block_thread = 0;
    twu.i_resolve_valid = 0; twu.i_resolve_thread = 0; twu.i_resolve_taken = 0;
    twu.i_resolve_target = '0; twu.i_halt_valid = 0; twu.i_halt_thread = 0;
    test_reset();
    test_round_robin();
    test_block_resolve();
    test_stall();
    test_halt_bubble();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
